// File: rtl/game_pkg.sv
// Shared types and helpers for the mental-math game answer-entry path.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EDIT_TENS  = 2'd1,
    ST_EDIT_UNITS = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         ANS_W   = 8;

  // tens*10 + units built from shifts so no multiplier is inferred.
  function automatic logic [ANS_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] t,
                                                  input logic [BCD_W-1:0] u);
    logic [ANS_W-1:0] tw;
    logic [ANS_W-1:0] uw;
    tw = {{(ANS_W-BCD_W){1'b0}}, t};
    uw = {{(ANS_W-BCD_W){1'b0}}, u};
    return (tw << 3) + (tw << 1) + uw;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? '0 : d + BCD_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, level debouncer, rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic level_reg;
  logic pulse_reg;
  logic [DB_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        // The DB_CYCLES-th consecutive disagreeing sample flips the level.
        if (cnt_reg == DB_W'(DB_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          pulse_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/bcd_answer_entry.sv
// Two-digit BCD answer entry with submit/ack handoff to the game controller.
// Optional auto-submit on inactivity is enabled by defining ENTRY_TIMEOUT_EN.
module bcd_answer_entry
  import game_pkg::*;
#(
  parameter int DB_CYCLES      = 16,
  parameter int DB_W           = 5,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TO_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             btn_inc,
  input  logic             btn_next,
  input  logic             btn_submit,
  input  logic             answer_ack,
  output logic [BCD_W-1:0] entry_tens,
  output logic [BCD_W-1:0] entry_units,
  output logic             digit_sel,
  output logic             editing,
  output logic [ANS_W-1:0] answer,
  output logic             answer_valid,
  output logic             timed_out
);

  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;

  assign btn_raw = {btn_submit, btn_next, btn_inc};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
      ) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_raw[gi]),
        .level (btn_level[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

  logic inc_pulse;
  logic next_pulse;
  logic submit_pulse;
  logic unused_levels;

  assign inc_pulse     = btn_pulse[0];
  assign next_pulse    = btn_pulse[1];
  assign submit_pulse  = btn_pulse[2];
  assign unused_levels = ^btn_level;

  state_t           state_reg;
  logic [BCD_W-1:0] tens_reg;
  logic [BCD_W-1:0] units_reg;
  logic [ANS_W-1:0] answer_reg;
  logic             valid_reg;
  logic             digit_sel_reg;
  logic             editing_reg;

`ifdef ENTRY_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_reg;
  logic            timed_out_reg;
  logic            timeout_hit;
  assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES[0] ^ TO_W[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tens_reg      <= '0;
      units_reg     <= '0;
      answer_reg    <= '0;
      valid_reg     <= 1'b0;
      digit_sel_reg <= 1'b0;
      editing_reg   <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      to_cnt_reg    <= '0;
      timed_out_reg <= 1'b0;
`endif
    end else if (arm) begin
      state_reg     <= ST_EDIT_TENS;
      tens_reg      <= '0;
      units_reg     <= '0;
      valid_reg     <= 1'b0;
      digit_sel_reg <= 1'b0;
      editing_reg   <= 1'b1;
`ifdef ENTRY_TIMEOUT_EN
      to_cnt_reg    <= '0;
      timed_out_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_EDIT_TENS, ST_EDIT_UNITS: begin
`ifdef ENTRY_TIMEOUT_EN
          if (inc_pulse || next_pulse || submit_pulse)
            to_cnt_reg <= '0;
          else
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
`endif
          if (submit_pulse) begin
            answer_reg    <= bcd_to_bin(tens_reg, units_reg);
            valid_reg     <= 1'b1;
            state_reg     <= ST_DONE;
            digit_sel_reg <= 1'b0;
            editing_reg   <= 1'b0;
          end else if (next_pulse) begin
            if (state_reg == ST_EDIT_TENS) begin
              state_reg     <= ST_EDIT_UNITS;
              digit_sel_reg <= 1'b1;
            end else begin
              state_reg     <= ST_EDIT_TENS;
              digit_sel_reg <= 1'b0;
            end
          end else if (inc_pulse) begin
            // Each digit wraps independently; no carry between them.
            if (state_reg == ST_EDIT_TENS)
              tens_reg <= bcd_inc(tens_reg);
            else
              units_reg <= bcd_inc(units_reg);
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (timeout_hit) begin
            answer_reg    <= bcd_to_bin(tens_reg, units_reg);
            valid_reg     <= 1'b1;
            state_reg     <= ST_DONE;
            digit_sel_reg <= 1'b0;
            editing_reg   <= 1'b0;
            timed_out_reg <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (answer_ack) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign entry_tens   = tens_reg;
  assign entry_units  = units_reg;
  assign digit_sel    = digit_sel_reg;
  assign editing      = editing_reg;
  assign answer       = answer_reg;
  assign answer_valid = valid_reg;
`ifdef ENTRY_TIMEOUT_EN
  assign timed_out    = timed_out_reg;
`else
  assign timed_out    = 1'b0;
`endif

endmodule
